// File: rtl/light_monitor.sv
// ---------------------------------------------------------------------------
// light_monitor
// Watches a one-hot traffic-light signal and checks that it walks
// green -> yellow -> red -> green, with every phase held for at least its
// minimum dwell and at most MAX_DWELL cycles. Violations raise sticky flags.
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   light[2:0]   observed light: 001 green, 010 yellow, 100 red, others illegal
//   err_clear    clears all sticky error flags (a same-edge new error wins)
//   phase[1:0]   tracked phase: 00 none, 01 green, 10 yellow, 11 red
//   dwell        consecutive cycles the current phase has been held
//   cycle_count  legal red-to-green transitions, wraps
//   err_enc      sticky: illegal light encoding seen
//   err_seq      sticky: out-of-order phase change seen
//   err_short    sticky: phase left before its minimum dwell
//   err_long     sticky: phase held longer than MAX_DWELL
// ---------------------------------------------------------------------------
module light_monitor #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_RED    = 4,
  parameter int MAX_DWELL  = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       light,
  input  logic             err_clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err_enc,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_long
);

  // State encoding equals the phase encoding, so phase is the state flop.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_RED    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

  // Map a light value to the phase it names; illegal codes map to ST_IDLE.
  function automatic state_t decode_light(input logic [2:0] l);
    state_t s;
    case (l)
      3'b001:  s = ST_GREEN;
      3'b010:  s = ST_YELLOW;
      3'b100:  s = ST_RED;
      default: s = ST_IDLE;
    endcase
    return s;
  endfunction

  // Legal successor of a tracking phase.
  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      ST_GREEN:  n = ST_YELLOW;
      ST_YELLOW: n = ST_RED;
      ST_RED:    n = ST_GREEN;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Minimum legal dwell of a tracking phase.
  function automatic logic [CNT_W-1:0] min_dwell(input state_t s);
    logic [CNT_W-1:0] m;
    case (s)
      ST_GREEN:  m = CNT_W'(MIN_GREEN);
      ST_YELLOW: m = CNT_W'(MIN_YELLOW);
      ST_RED:    m = CNT_W'(MIN_RED);
      default:   m = {CNT_W{1'b0}};
    endcase
    return m;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] dwell_r, dwell_s;
  logic [CNT_W-1:0] cycle_r, cycle_s;
  logic             first_r, first_s;
  logic             err_enc_r, err_seq_r, err_short_r, err_long_r;
  logic             enc_set_s, seq_set_s, short_set_s, long_set_s;
  state_t           light_st_s;

  // Next-state, dwell, cycle counter and error-event decode.
  always_comb begin
    state_s     = state_r;
    dwell_s     = dwell_r;
    cycle_s     = cycle_r;
    first_s     = first_r;
    enc_set_s   = 1'b0;
    seq_set_s   = 1'b0;
    short_set_s = 1'b0;
    long_set_s  = 1'b0;
    light_st_s  = decode_light(light);

    case (state_r)
      ST_IDLE: begin
        if (light_st_s == ST_IDLE) begin
          enc_set_s = 1'b1;
          dwell_s   = {CNT_W{1'b0}};
        end else begin
          // First phase after IDLE may be partial, so its exit is not timed.
          state_s = light_st_s;
          dwell_s = DWELL_ONE;
          first_s = 1'b1;
        end
      end
      ST_GREEN, ST_YELLOW, ST_RED: begin
        if (light_st_s == ST_IDLE) begin
          enc_set_s = 1'b1;
          state_s   = ST_IDLE;
          dwell_s   = {CNT_W{1'b0}};
          first_s   = 1'b0;
        end else if (light_st_s == state_r) begin
          if (dwell_r == DWELL_MAX) begin
            long_set_s = 1'b1;
          end else begin
            long_set_s = 1'b0;
          end
          if (dwell_r != DWELL_SAT) begin
            dwell_s = dwell_r + DWELL_ONE;
          end else begin
            dwell_s = dwell_r;
          end
        end else if (light_st_s == next_phase(state_r)) begin
          state_s = light_st_s;
          dwell_s = DWELL_ONE;
          first_s = 1'b0;
          if (!first_r && (dwell_r < min_dwell(state_r))) begin
            short_set_s = 1'b1;
          end else begin
            short_set_s = 1'b0;
          end
          if (state_r == ST_RED) begin
            cycle_s = cycle_r + DWELL_ONE;
          end else begin
            cycle_s = cycle_r;
          end
        end else begin
          // Out-of-order: resynchronise, and treat the new phase as partial.
          seq_set_s = 1'b1;
          state_s   = light_st_s;
          dwell_s   = DWELL_ONE;
          first_s   = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        dwell_s = {CNT_W{1'b0}};
        first_s = 1'b0;
      end
    endcase
  end

  // State, counters and sticky flags; a new error beats err_clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dwell_r     <= {CNT_W{1'b0}};
      cycle_r     <= {CNT_W{1'b0}};
      first_r     <= 1'b0;
      err_enc_r   <= 1'b0;
      err_seq_r   <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      dwell_r     <= dwell_s;
      cycle_r     <= cycle_s;
      first_r     <= first_s;
      err_enc_r   <= (err_enc_r   & ~err_clear) | enc_set_s;
      err_seq_r   <= (err_seq_r   & ~err_clear) | seq_set_s;
      err_short_r <= (err_short_r & ~err_clear) | short_set_s;
      err_long_r  <= (err_long_r  & ~err_clear) | long_set_s;
    end
  end

  assign phase       = state_r;
  assign dwell       = dwell_r;
  assign cycle_count = cycle_r;
  assign err_enc     = err_enc_r;
  assign err_seq     = err_seq_r;
  assign err_short   = err_short_r;
  assign err_long    = err_long_r;

endmodule

// File: tb/tb_light_monitor.sv
// ---------------------------------------------------------------------------
// tb_light_monitor
// Directed bench for light_monitor with default parameters. Observed outputs
// are packed as {phase, dwell, cycle_count, err_enc, err_seq, err_short,
// err_long} and compared against hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_light_monitor;

  logic       clock;
  logic       reset;
  logic [2:0] light;
  logic       err_clear;
  logic [1:0] phase;
  logic [7:0] dwell;
  logic [7:0] cycle_count;
  logic       err_enc, err_seq, err_short, err_long;

  logic [21:0] obs;
  logic [21:0] exp_v;
  int compared;
  int mismatched;

  light_monitor #(
    .CNT_W(8), .MIN_GREEN(4), .MIN_YELLOW(2), .MIN_RED(4), .MAX_DWELL(200)
  ) dut (
    .clock(clock), .reset(reset), .light(light), .err_clear(err_clear),
    .phase(phase), .dwell(dwell), .cycle_count(cycle_count),
    .err_enc(err_enc), .err_seq(err_seq), .err_short(err_short),
    .err_long(err_long)
  );

  assign obs = {phase, dwell, cycle_count, err_enc, err_seq, err_short, err_long};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one light value for one edge, then sample 1 time unit later.
  task automatic step(input logic [2:0] l);
    light = l;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; err_clear = 1'b0;
    step(3'b001);
    step(3'b001);
    exp_v = {2'b00, 8'd0, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_normal_cycle();
    step(3'b001);
    exp_v = {2'b01, 8'd1, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL green_entry: got %h expected %h", obs, exp_v); end
    for (int i = 0; i < 3; i++) step(3'b001);
    exp_v = {2'b01, 8'd4, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL green_dwell4: got %h expected %h", obs, exp_v); end
    step(3'b010);
    step(3'b010);
    exp_v = {2'b10, 8'd2, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL yellow_dwell2: got %h expected %h", obs, exp_v); end
    for (int i = 0; i < 4; i++) step(3'b100);
    exp_v = {2'b11, 8'd4, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL red_dwell4: got %h expected %h", obs, exp_v); end
    step(3'b001);
    exp_v = {2'b01, 8'd1, 8'd1, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL red_to_green: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_short();
    step(3'b001);
    step(3'b010);
    exp_v = {2'b10, 8'd1, 8'd1, 4'b0010}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL short_green: got %h expected %h", obs, exp_v); end
    err_clear = 1'b1;
    step(3'b010);
    err_clear = 1'b0;
    exp_v = {2'b10, 8'd2, 8'd1, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL short_clear: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_seq();
    for (int i = 0; i < 4; i++) step(3'b100);
    step(3'b001);
    exp_v = {2'b01, 8'd1, 8'd2, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL seq_setup: got %h expected %h", obs, exp_v); end
    step(3'b100);
    exp_v = {2'b11, 8'd1, 8'd2, 4'b0100}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL seq_green_red: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_enc();
    err_clear = 1'b1;
    step(3'b100);
    err_clear = 1'b0;
    exp_v = {2'b11, 8'd2, 8'd2, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL enc_clear: got %h expected %h", obs, exp_v); end
    step(3'b100);
    step(3'b100);
    for (int i = 0; i < 4; i++) step(3'b001);
    exp_v = {2'b01, 8'd4, 8'd3, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL enc_setup: got %h expected %h", obs, exp_v); end
    step(3'b010);
    step(3'b010);
    step(3'b011);
    exp_v = {2'b00, 8'd0, 8'd3, 4'b1000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL enc_illegal: got %h expected %h", obs, exp_v); end
    step(3'b100);
    exp_v = {2'b11, 8'd1, 8'd3, 4'b1000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL enc_reentry: got %h expected %h", obs, exp_v); end
    step(3'b001);
    exp_v = {2'b01, 8'd1, 8'd4, 4'b1000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL enc_no_short: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_long();
    err_clear = 1'b1;
    step(3'b001);
    err_clear = 1'b0;
    step(3'b001);
    step(3'b001);
    step(3'b010);
    step(3'b010);
    step(3'b100);
    for (int i = 0; i < 199; i++) step(3'b100);
    exp_v = {2'b11, 8'd200, 8'd4, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL long_at_max: got %h expected %h", obs, exp_v); end
    step(3'b100);
    exp_v = {2'b11, 8'd201, 8'd4, 4'b0001}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL long_over: got %h expected %h", obs, exp_v); end
    for (int i = 0; i < 54; i++) step(3'b100);
    exp_v = {2'b11, 8'd255, 8'd4, 4'b0001}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL long_255: got %h expected %h", obs, exp_v); end
    for (int i = 0; i < 3; i++) step(3'b100);
    exp_v = {2'b11, 8'd255, 8'd4, 4'b0001}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL long_saturate: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    step(3'b001);
    exp_v = {2'b01, 8'd1, 8'd5, 4'b0001}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_from_sat: got %h expected %h", obs, exp_v); end
    step(3'b100);
    step(3'b001);
    step(3'b010);
    step(3'b111);
    step(3'b100);
    for (int i = 0; i < 49; i++) step(3'b100);
    exp_v = {2'b11, 8'd50, 8'd6, 4'b1111}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_all_flags: got %h expected %h", obs, exp_v); end
    reset = 1'b1;
    step(3'b100);
    exp_v = {2'b00, 8'd0, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL mid_reset: got %h expected %h", obs, exp_v); end
    reset = 1'b0;
    step(3'b001);
    exp_v = {2'b01, 8'd1, 8'd0, 4'b0000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL post_reset_entry: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_clear_set_wins();
    step(3'b100);
    exp_v = {2'b11, 8'd1, 8'd0, 4'b0100}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL csw_seq: got %h expected %h", obs, exp_v); end
    err_clear = 1'b1;
    step(3'b011);
    err_clear = 1'b0;
    exp_v = {2'b00, 8'd0, 8'd0, 4'b1000}; compared++;
    if (obs !== exp_v) begin mismatched++; $display("FAIL csw_enc_wins: got %h expected %h", obs, exp_v); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    err_clear  = 1'b0;
    light      = 3'b000;
    test_reset();
    test_normal_cycle();
    test_short();
    test_seq();
    test_enc();
    test_long();
    test_reset_mid();
    test_clear_set_wins();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the dwell and cycle counters.
REQ-002 Parameter MIN_GREEN, default 4: minimum legal green dwell, in cycles.
REQ-003 Parameter MIN_YELLOW, default 2: minimum legal yellow dwell, in cycles.
REQ-004 Parameter MIN_RED, default 4: minimum legal red dwell, in cycles.
REQ-005 Parameter MAX_DWELL, default 200: maximum legal dwell for any phase, in cycles; must be less than 2^CNT_W-1.
REQ-006 Port: clock, input, 1 bit; the single clock; all logic on its rising edge.
REQ-007 Port: reset, input, 1 bit; synchronous, active-high.
REQ-008 Port: light, input, 3 bits; traffic-light output under observation. Encodings: 3'b001 green, 3'b010 yellow, 3'b100 red; all other values are illegal.
REQ-009 Port: err_clear, input, 1 bit; clears the sticky error flags.
REQ-010 Port: phase, output, 2 bits; decoded current phase: 00 none, 01 green, 10 yellow, 11 red.
REQ-011 Port: dwell, output, CNT_W bits; number of consecutive cycles the current phase has been held.
REQ-012 Port: cycle_count, output, CNT_W bits; count of legal red-to-green transitions.
REQ-013 Port: err_enc, output, 1 bit; sticky flag for an illegal light encoding.
REQ-014 Port: err_seq, output, 1 bit; sticky flag for an out-of-order phase change.
REQ-015 Port: err_short, output, 1 bit; sticky flag for a phase exited before its minimum dwell.
REQ-016 Port: err_long, output, 1 bit; sticky flag for a phase held longer than MAX_DWELL.

Function
REQ-017 light shall be sampled on each rising clock edge, and all outputs shall be registered and updated on that same edge (one-cycle latency from input to output).
REQ-018 The FSM shall have four states: IDLE, GREEN, YELLOW, RED; phase shall reflect the state (IDLE maps to 00).
REQ-019 From IDLE, a legal light value shall move the FSM to the matching state, set dwell to 1, and set an internal first_phase marker.
REQ-020 An illegal light value in IDLE shall set err_enc and keep the FSM in IDLE with dwell at 0.
REQ-021 When light is unchanged in a tracking state, dwell shall increment by 1 and saturate at 2^CNT_W-1.
REQ-022 A legal next phase (GREEN to YELLOW, YELLOW to RED, RED to GREEN) shall move the FSM to that state, set dwell to 1, and clear first_phase.
REQ-023 On a legal phase change, err_short shall be set if the outgoing dwell is below the outgoing phase's MIN_*; this check shall be skipped while first_phase is set.
REQ-024 A legal encoding that is out of order (for example GREEN to RED) shall set err_seq and resynchronise to the new phase with dwell 1, with first_phase set and no err_short check.
REQ-025 An illegal encoding in any tracking state shall set err_enc, move the FSM to IDLE, and set dwell to 0.
REQ-026 err_long shall be set on the edge where dwell would increment from MAX_DWELL to MAX_DWELL+1; the state shall be held.
REQ-027 cycle_count shall increment by 1 on each legal RED-to-GREEN transition, including those flagged err_short, and wrap modulo 2^CNT_W.
REQ-028 err_clear=1 shall clear all four error flags on that edge; if a new error condition occurs on the same edge, that flag shall be set (set wins).
REQ-029 Error flags shall have no effect on FSM tracking or on the counters.

Reset
REQ-030 reset=1 at a rising edge shall force: state IDLE, phase 00, dwell 0, cycle_count 0, all error flags 0, first_phase 0; light is ignored on that edge.
REQ-031 reset shall take priority over err_clear and over every transition, including when asserted mid-phase; the first post-reset legal sample shall follow REQ-019.

Verification
REQ-032 Reset, then light=001 for 4 cycles, 010 for 2, 100 for 4, then 001 -> phase sequence 01,10,11,01; cycle_count=1; all error flags 0.
REQ-033 Steady cycle established, then green held 2 cycles before 010 -> err_short=1 on the transition edge; then err_clear pulse -> err_short=0.
REQ-034 In GREEN, drive light=100 -> err_seq=1; phase=11; dwell=1; cycle_count unchanged.
REQ-035 In YELLOW, drive light=011 for 1 cycle, then 100 -> err_enc=1; phase 00 with dwell 0; then phase 11 with dwell 1; no err_short on the next exit from red.
REQ-036 Hold red for 201 cycles -> err_long=1 on the edge where dwell reaches 201; dwell continues to 255 and saturates.
REQ-037 Assert reset mid-red with dwell=50 and all error flags set -> next cycle shows phase 00, dwell 0, cycle_count 0, all flags 0.
